mar_agu: RTL
============

// Module: mar_agu
// PURPOSE
//  Parametrised memory address register with address generation: loads from c_bus,
//  auto-steps by a programmable stride with wrap inside a [base, limit] window, and
//  runs a req/ack handshake to memory. memory_address is held stable during an access.
//  Sits between the datapath C bus and the memory port; feeds downsampling scan loops.
// PARAMETERS
//  ADDR_W    16  width of memory_address, base, limit
//  BUS_W     16  width of c_bus (BUS_W >= ADDR_W; low ADDR_W bits used)
//  STRIDE_W  8   width of stride register (unsigned)
// PORTS
//  clk             in   1         system clock, rising edge
//  rst_n           in   1         asynchronous, active-low reset
//  write_enable    in   1         load memory_address <= c_bus[ADDR_W-1:0]
//  c_bus           in   BUS_W     datapath C bus
//  cfg_we          in   1         write config register selected by cfg_sel from c_bus
//  cfg_sel         in   2         0=base, 1=limit, 2=stride, 3=reserved (write ignored)
//  step_en         in   1         advance address by stride (wrap rules below)
//  acc_start       in   1         begin memory access at current address
//  acc_auto_step   in   1         sampled with acc_start: step after ack
//  mem_ack         in   1         memory completes access
//  memory_address  out  ADDR_W    current address
//  mem_req         out  1         access request to memory
//  busy            out  1         FSM not IDLE
//  acc_done        out  1         1-cycle pulse, access finished
//  wrap            out  1         1-cycle pulse, a step wrapped to base
// BEHAVIOUR
//  Reset (async, rst_n=0): memory_address=0, base=0, limit=all-ones, stride=1,
//   state=IDLE, mem_req=0, busy=0, acc_done=0, wrap=0. Release: synchronous effect only.
//  All register updates on rising clk; effects visible next cycle (1-cycle latency).
//  Step: sum = {1'b0,addr} + stride (ADDR_W+1 bits). If sum[ADDR_W]=1 or sum > limit
//   -> addr <= base, wrap pulse. Else addr <= sum[ADDR_W-1:0]. stride=0 -> addr holds, no wrap.
//   limit < base (misconfig): every nonzero step wraps to base.
//  Config writes: base/limit/stride take c_bus low bits; stride truncated to STRIDE_W.
//   Config change does not move addr; new values apply from next step.
//  FSM states: IDLE, REQ, DONE.
//   IDLE: priority write_enable > step_en; cfg_we independent (same cycle allowed).
//     acc_start=1 -> REQ, latch acc_auto_step; acc_start wins over step_en, loses to
//     nothing except write_enable, which is applied first (access uses loaded address).
//   REQ: mem_req=1, busy=1; write_enable, step_en, cfg_we, acc_start ignored; addr frozen.
//     mem_ack=1 -> DONE; if latched auto_step, step applied on this edge (wrap may pulse).
//   DONE: acc_done=1, busy=1, mem_req=0 for exactly one cycle -> IDLE. Inputs ignored.
//  mem_ack outside REQ ignored. mem_ack same cycle mem_req first rises: not possible
//   (req registered); earliest completion is one cycle after acc_start.
//  Reset mid-access: mem_req drops immediately (async), all state to reset values.
// STRUCTURE
//  Shared package mar_pkg: FSM state encoding (IDLE/REQ/DONE), CFG_BASE/CFG_LIMIT/
//   CFG_STRIDE/CFG_RSVD constants, reset values of config registers.
//  Sub-module mar_step_unit: combinational {addr,base,limit,stride} -> {next_addr, wrapped};
//   used by both direct step and auto-step paths. Top holds registers and FSM.
// TESTING
//  1 Reset: drive rst_n=0 mid-REQ -> mem_req=0 same cycle, addr=0, limit=16'hFFFF, stride=1.
//  2 Load/step: write_enable c_bus=16'h0100, cfg stride=4, 3x step_en -> 0104,0108,010C, wrap=0.
//  3 Wrap: base=0x0010, limit=0x001F, addr=0x001C, stride=4 -> step gives 0x0010, wrap pulse 1 cycle;
//    addr=0xFFFE, limit=0xFFFF, stride=3 -> carry -> base.
//  4 Handshake: acc_start+auto_step at addr 0x0020, stride 2, ack after 3 cycles -> mem_req high
//    3 cycles with addr 0x0020, then acc_done pulse, addr 0x0022, busy low next cycle.
//  5 Conflicts: during REQ pulse write_enable/step_en/cfg_we -> addr, config unchanged;
//    in IDLE write_enable+step_en same cycle -> loaded value, no step.
//  6 Edge config: stride=0 step -> addr holds, no wrap; limit<base -> step wraps to base.

Source files
------------

// File: rtl/mar_pkg.sv
// Shared definitions for the memory address register / address generator.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mar_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } mar_state_t;

    localparam logic [1:0] CFG_BASE   = 2'd0;
    localparam logic [1:0] CFG_LIMIT  = 2'd1;
    localparam logic [1:0] CFG_STRIDE = 2'd2;
    localparam logic [1:0] CFG_RSVD   = 2'd3;

    // Limit resets to all-ones, so its reset value is expressed as a fill flag.
    localparam int RST_BASE       = 0;
    localparam int RST_STRIDE     = 1;
    localparam bit RST_LIMIT_ONES = 1'b1;

endpackage

// File: rtl/mar_step_unit.sv
// Next-address computation: addr + stride, wrapping to base on carry, overrun of limit or limit<base.
// Latency: combinational.
// Backpressure: none; the caller decides when the result is committed.
module mar_step_unit #(
    parameter int ADDR_W   = 16,
    parameter int STRIDE_W = 8
) (
    input  logic [ADDR_W-1:0]   addr,
    input  logic [ADDR_W-1:0]   base,
    input  logic [ADDR_W-1:0]   limit,
    input  logic [STRIDE_W-1:0] stride,
    output logic [ADDR_W-1:0]   next_addr,
    output logic                wrapped
);

    logic [ADDR_W:0] sum;

    assign sum = {1'b0, addr} + (ADDR_W+1)'(stride);

    always_comb begin
        next_addr = addr;
        wrapped   = 1'b0;
        if (stride != '0) begin
            // A misconfigured window (limit below base) forces every step back to base.
            if (sum[ADDR_W] || (sum[ADDR_W-1:0] > limit) || (limit < base)) begin
                next_addr = base;
                wrapped   = 1'b1;
            end else begin
                next_addr = sum[ADDR_W-1:0];
            end
        end
    end

endmodule

// File: rtl/mar_agu.sv
// Memory address register with strided, windowed stepping and a req/ack memory access FSM.
// Latency: all register updates visible one cycle after the controlling input.
// Backpressure: mem_req held (address frozen) until mem_ack; inputs ignored while busy.
module mar_agu
    import mar_pkg::*;
#(
    parameter int ADDR_W   = 16,
    parameter int BUS_W    = 16,
    parameter int STRIDE_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              write_enable,
    input  logic [BUS_W-1:0]  c_bus,
    input  logic              cfg_we,
    input  logic [1:0]        cfg_sel,
    input  logic              step_en,
    input  logic              acc_start,
    input  logic              acc_auto_step,
    input  logic              mem_ack,
    output logic [ADDR_W-1:0] memory_address,
    output logic              mem_req,
    output logic              busy,
    output logic              acc_done,
    output logic              wrap
);

    mar_state_t          state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [ADDR_W-1:0]   limit_q, limit_d;
    logic [STRIDE_W-1:0] stride_q, stride_d;
    logic                auto_q, auto_d;
    logic                wrap_q, wrap_d;

    logic [ADDR_W-1:0]   step_addr;
    logic                step_wrap;

    generate
        if (BUS_W > ADDR_W) begin : g_bus_hi
            logic unused_bus_hi;
            assign unused_bus_hi = ^c_bus[BUS_W-1:ADDR_W];
        end
    endgenerate

    mar_step_unit #(
        .ADDR_W   (ADDR_W),
        .STRIDE_W (STRIDE_W)
    ) u_step (
        .addr      (addr_q),
        .base      (base_q),
        .limit     (limit_q),
        .stride    (stride_q),
        .next_addr (step_addr),
        .wrapped   (step_wrap)
    );

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        base_d   = base_q;
        limit_d  = limit_q;
        stride_d = stride_q;
        auto_d   = auto_q;
        wrap_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cfg_we) begin
                    case (cfg_sel)
                        CFG_BASE:   base_d   = c_bus[ADDR_W-1:0];
                        CFG_LIMIT:  limit_d  = c_bus[ADDR_W-1:0];
                        CFG_STRIDE: stride_d = c_bus[STRIDE_W-1:0];
                        CFG_RSVD:   ;
                    endcase
                end
                // A load lands before an access starts; a start suppresses a same-cycle step.
                if (write_enable) begin
                    addr_d = c_bus[ADDR_W-1:0];
                end else if (step_en && !acc_start) begin
                    addr_d = step_addr;
                    wrap_d = step_wrap;
                end
                if (acc_start) begin
                    state_d = ST_REQ;
                    auto_d  = acc_auto_step;
                end
            end
            ST_REQ: begin
                if (mem_ack) begin
                    state_d = ST_DONE;
                    if (auto_q) begin
                        addr_d = step_addr;
                        wrap_d = step_wrap;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            base_q   <= ADDR_W'(RST_BASE);
            limit_q  <= {ADDR_W{RST_LIMIT_ONES}};
            stride_q <= STRIDE_W'(RST_STRIDE);
            auto_q   <= 1'b0;
            wrap_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            base_q   <= base_d;
            limit_q  <= limit_d;
            stride_q <= stride_d;
            auto_q   <= auto_d;
            wrap_q   <= wrap_d;
        end
    end

    assign memory_address = addr_q;
    assign mem_req        = (state_q == ST_REQ);
    assign busy           = (state_q != ST_IDLE);
    assign acc_done       = (state_q == ST_DONE);
    assign wrap           = wrap_q;

endmodule
